// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and port owner IDs.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant: on a tie the requester that did not win last time is chosen.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // gnt[0] is the CPU, gnt[1] is the host
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == OWN_HOST) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-ported fixed-latency data memory between the CPU data port and a host loader,
// stalling the CPU until its access completes.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        host_req,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic [3:0]  host_we,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       we_q;
    logic [31:0]      rdata_q;
    logic [31:0]      cpu_rdata_q;
    logic [31:0]      host_rdata_q;
    logic [1:0]       gnt;
    logic             done_cpu;
    logic             done_host_rd;

    arb_rr2 u_arb (
        .req  ({host_req, cpu_req}),
        .last (last_owner),
        .gnt  (gnt)
    );

    assign done_cpu     = (state == S_DONE) && (owner == OWN_CPU);
    assign done_host_rd = (state == S_DONE) && (owner == OWN_HOST) && (we_q == 4'h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            owner        <= OWN_CPU;
            last_owner   <= OWN_HOST;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= '0;
            rdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner      <= gnt[1];
                        last_owner <= gnt[1];
                        addr_q     <= gnt[1] ? host_addr  : cpu_addr;
                        wdata_q    <= gnt[1] ? host_wdata : cpu_wdata;
                        we_q       <= gnt[1] ? host_we    : cpu_we;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q != 4'h0) begin
                        state <= S_DONE;
                    end else if (MEM_LATENCY == 1) begin
                        rdata_q <= mem_rdata;
                        state   <= S_DONE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= S_WAIT;
                    end
                end
                // Read data is valid in the WAIT cycle whose decrement brings cnt to zero
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rdata_q <= mem_rdata;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_cpu) begin
                        cpu_rdata_q <= rdata_q;
                    end
                    if (done_host_rd) begin
                        host_rdata_q <= rdata_q;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_en      = (state == S_ISSUE);
    assign mem_we      = (state == S_ISSUE) ? we_q : 4'h0;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign host_gnt    = (state == S_ISSUE) && (owner == OWN_HOST);
    assign host_rvalid = done_host_rd;
    assign host_rdata  = done_host_rd ? rdata_q : host_rdata_q;
    assign cpu_rdata   = done_cpu ? rdata_q : cpu_rdata_q;
    assign cpu_stall   = cpu_req & ~done_cpu;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 3-cycle-latency behavioural memory.
module tb_dmem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        host_req;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [3:0]  host_we;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_port_arbiter #(.MEM_LATENCY(LAT), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_we     (host_we),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: read data for an access strobed in cycle t is on mem_rdata in cycle t+LAT-1
    logic [31:0] mem [0:63];
    logic [31:0] rd_p1 = '0;
    logic [31:0] rd_p2 = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        rd_p1 <= mem[mem_addr[7:2]];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        e_stall;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] we, input logic e_stall, input logic e_en,
                                input logic [3:0] e_we, input logic [31:0] e_rdata);
        vec_t v;
        v.req = req; v.addr = addr; v.wdata = wdata; v.we = we;
        v.e_stall = e_stall; v.e_en = e_en; v.e_we = e_we; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int lat;
        int rv_cnt;
        int nstall;
        int nen;
        logic [3:0] order;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[8] = 32'h1234_5678;

        // Store then load at 0x10; req held through DONE on the store
        vt[0] = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 4'h0, 32'h0);
        vt[1] = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 4'hF, 32'h0);
        vt[2] = mk(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 4'h0, 32'h0);
        vt[3] = mk(1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        vt[4] = mk(1'b1, 32'h10, 32'h0,         4'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        vt[5] = mk(1'b1, 32'h10, 32'h0,         4'h0, 1'b1, 1'b1, 4'h0, 32'h0);
        vt[6] = mk(1'b1, 32'h10, 32'h0,         4'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        vt[7] = mk(1'b1, 32'h10, 32'h0,         4'h0, 1'b1, 1'b0, 4'h0, 32'h0);
        vt[8] = mk(1'b1, 32'h10, 32'h0,         4'h0, 1'b0, 1'b0, 4'h0, 32'hDEAD_BEEF);
        vt[9] = mk(1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1'b0, 4'h0, 32'hDEAD_BEEF);

        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = '0;
        host_req = 1'b0; host_addr = '0; host_wdata = '0; host_we = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 4'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_host_gnt", host_gnt, 1'b0);
        chk("rst_host_rvalid", host_rvalid, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        chk("rst_stall_follows_req1", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        #1;
        chk("rst_stall_follows_req0", cpu_stall, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cpu_req = vt[i].req; cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata; cpu_we = vt[i].we;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), cpu_stall, vt[i].e_stall);
            chk($sformatf("v%0d_mem_en", i), mem_en, vt[i].e_en);
            chk($sformatf("v%0d_mem_we", i), mem_we, vt[i].e_we);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vt[i].e_rdata);
            chk($sformatf("v%0d_host_gnt", i), host_gnt, 1'b0);
            if (vt[i].e_en) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, 32'h10);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].wdata);
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;

        // Host read of preloaded word
        host_req = 1'b1; host_addr = 32'h20; host_we = 4'h0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (host_gnt) begin
                seen = 1;
                chk("host_rd_mem_addr", mem_addr, 32'h20);
                chk("host_rd_mem_en", mem_en, 1'b1);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("host_gnt_seen", seen, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (host_rvalid) begin
                lat = k;
                chk("host_rdata", host_rdata, 32'h1234_5678);
            end
        end
        chk("host_rvalid_latency", lat, LAT);
        @(negedge clk);
        chk("host_rvalid_pulse", host_rvalid, 1'b0);
        chk("host_rdata_hold", host_rdata, 32'h1234_5678);

        // Simultaneous requests right after reset: CPU, host, CPU, host
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA_0001; cpu_we = 4'hF;
        host_req = 1'b1; host_addr = 32'h34; host_wdata = 32'h5555_0002; host_we = 4'hF;
        seen = 0;
        order = '0;
        for (int k = 0; k < 40 && seen < 4; k++) begin
            @(negedge clk);
            if (mem_en) begin
                order[seen] = (mem_addr == 32'h34);
                chk($sformatf("arb_host_gnt_%0d", seen), host_gnt, (mem_addr == 32'h34));
                seen++;
            end
            @(posedge clk); #1;
        end
        chk("arb_issue_count", seen, 4);
        chk("arb_order", order, 4'b1010);
        cpu_req = 1'b0; host_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arb_cpu_mem", mem[12], 32'hAAAA_0001);
        chk("arb_host_mem", mem[13], 32'h5555_0002);

        // Reset during WAIT of a host read
        host_req = 1'b1; host_addr = 32'h20; host_we = 4'h0;
        @(posedge clk); #1;
        chk("rw_issue_gnt", host_gnt, 1'b1);
        @(posedge clk); #1;
        host_req = 1'b0;
        chk("rw_in_wait_en", mem_en, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_rst_mem_en", mem_en, 1'b0);
        chk("rw_rst_rvalid", host_rvalid, 1'b0);
        chk("rw_rst_mem_we", mem_we, 4'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (host_rvalid) rv_cnt++;
        end
        chk("rw_no_rvalid", rv_cnt, 0);

        // Next access after the aborted one proceeds normally
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h10; cpu_wdata = '0; cpu_we = 4'h0;
        nstall = 0;
        nen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_en) nen++;
            if (!cpu_stall) begin
                chk("post_rst_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
                break;
            end
            nstall++;
            @(posedge clk); #1;
        end
        chk("post_rst_stall_cycles", nstall, 4);
        chk("post_rst_mem_en_count", nen, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_en", mem_en, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
